// File: rtl/hilo_muldiv_if.sv
// HI/LO write-side bundle between the pipeline and the iterative mul/div unit.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcAE;
    logic [WIDTH-1:0] srcBE;
    logic             mthiW;
    logic             mtloW;
    logic [WIDTH-1:0] wdataW;
    logic [WIDTH-1:0] hiout;
    logic [WIDTH-1:0] loout;
    logic             busy;
    logic             doneP;

    modport master (
        output startE, opE, srcAE, srcBE, mthiW, mtloW, wdataW,
        input  hiout, loout, busy, doneP
    );

    modport slave (
        input  startE, opE, srcAE, srcBE, mthiW, mtloW, wdataW,
        output hiout, loout, busy, doneP
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting for an issue from EX; HI/LO only change via MTHI/MTLO
// RUN   | one shift-add / restoring-divide step per cycle, counter counts down
// FIN   | sign fix-up applied, HI/LO committed at the end of this cycle
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic         clk,
    input logic         rst_n,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(ITER + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      iterCnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   origA;
    logic               isDiv;
    logic               negLo;
    logic               negHi;
    logic               divZero;
    logic               busyReg;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;

    logic               isSigned;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               accept;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     divPart;
    logic [WIDTH:0]     divDiff;
    logic               divFits;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] iterNext;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;
    logic               commit;

    // Operand magnitudes and sign bits at issue; MULTU/DIVU (opE[0]=1) are taken as-is.
    always_comb begin
        isSigned = ~bus.opE[0];
        signA    = isSigned & bus.srcAE[WIDTH-1];
        signB    = isSigned & bus.srcBE[WIDTH-1];
        absA     = signA ? -bus.srcAE : bus.srcAE;
        absB     = signB ? -bus.srcBE : bus.srcBE;
        accept   = (state == IDLE) && bus.startE;
    end

    // One datapath step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mulNext  = {mulSum, acc[WIDTH-1:1]};
        divPart  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff  = divPart - {1'b0, opnd};
        divFits  = (divPart >= {1'b0, opnd});
        divNext  = {(divFits ? divDiff[WIDTH-1:0] : divPart[WIDTH-1:0]), acc[WIDTH-2:0], divFits};
        iterNext = isDiv ? divNext : mulNext;
    end

    // Final sign fix-up; divide-by-zero overrides the (meaningless) restoring result.
    always_comb begin
        prod   = negLo ? -acc : acc;
        resHi  = prod[2*WIDTH-1:WIDTH];
        resLo  = prod[WIDTH-1:0];
        if (isDiv) begin
            if (divZero) begin
                resHi = origA;
                resLo = {WIDTH{1'b1}};
            end else begin
                resHi = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                resLo = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
        commit = (state == FIN);
    end

    // Sequencer: latch operands at issue, iterate ITER times, then one commit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iterCnt <= '0;
            acc     <= '0;
            opnd    <= '0;
            origA   <= '0;
            isDiv   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
            busyReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        iterCnt <= CW'(ITER);
                        busyReg <= 1'b1;
                        isDiv   <= bus.opE[1];
                        origA   <= bus.srcAE;
                        negLo   <= signA ^ signB;
                        negHi   <= bus.opE[1] & signA;
                        divZero <= bus.opE[1] & (bus.srcBE == {WIDTH{1'b0}});
                        if (bus.opE[1]) begin
                            acc  <= {{WIDTH{1'b0}}, absA};
                            opnd <= absB;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, absB};
                            opnd <= absA;
                        end
                    end
                end
                RUN: begin
                    acc     <= iterNext;
                    iterCnt <= iterCnt - CW'(1);
                    if (iterCnt == CW'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    // Architectural HI/LO: the FIN commit takes priority over a same-edge MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (commit) begin
            hiReg <= resHi;
            loReg <= resLo;
        end else begin
            if (bus.mthiW) begin
                hiReg <= bus.wdataW;
            end
            if (bus.mtloW) begin
                loReg <= bus.wdataW;
            end
        end
    end

    assign bus.hiout = hiReg;
    assign bus.loout = loReg;
    assign bus.busy  = busyReg;
    assign bus.doneP = commit;
endmodule
